// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage.
// Holds the fetch FSM encoding and the buffered {pc, instr} entry.
package fetch_unit_pkg;

  localparam int          XLEN         = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(
    input logic [XLEN-1:0] a
  );
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush, shared by instruction and data paths.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // flush wins over a simultaneous push or pop
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding icache request at a time,
// responses buffered in a small FIFO toward decode, flushed on redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ic_addr,
  output logic        ic_req,
  input  logic [31:0] ic_rdata,
  input  logic        ic_ready,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_instr
);

  localparam int          CW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  fetch_entry_t  wr_entry;
  fetch_entry_t  head;

  // ic_addr still holds the address of the request being answered
  assign push     = (state == WAIT) && ic_ready && !redirect_valid;
  assign pop      = dec_valid && dec_ready;
  assign wr_entry = '{pc: ic_addr, instr: ic_rdata};

  assign dec_valid = (count != '0);
  assign dec_pc    = head.pc;
  assign dec_instr = head.instr;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (wr_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ic_req   <= 1'b0;
      ic_addr  <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else begin
      ic_req <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!redirect_valid && count < FULL) begin
            ic_req  <= 1'b1;
            ic_addr <= fetch_pc;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (ic_ready) begin
            state <= IDLE;
            if (!redirect_valid) begin
              fetch_pc <= fetch_pc + 32'd4;
            end
          end else if (redirect_valid) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (ic_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (redirect_valid) begin
        fetch_pc <= align_word(redirect_pc);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level model of the
// fetch stream plus an icache responder with programmable latency.
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] ic_addr;
  logic        ic_req;
  logic [31:0] ic_rdata;
  logic        ic_ready;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC   (RPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ic_addr        (ic_addr),
    .ic_req         (ic_req),
    .ic_rdata       (ic_rdata),
    .ic_ready       (ic_ready),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_pc         (dec_pc),
    .dec_instr      (dec_instr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [31:0] mq_pc[$];
  logic [31:0] mq_in[$];
  bit          busy = 0;
  bit          live = 0;
  logic [31:0] out_addr = '0;
  logic [31:0] nxt_pc = RPC;
  logic [31:0] exp_addr = RPC;

  // observation logs
  logic [31:0] acc_pc[$];
  logic [31:0] acc_in[$];
  logic [31:0] req_log[$];
  bit          p_req = 0;
  bit          p_valid = 0;
  logic [31:0] p_pc = '0;
  logic [31:0] p_instr = '0;

  // icache responder
  int          lat = 1;
  bit          ovr = 0;
  bit          pend = 0;
  int          cnt = 0;
  logic [31:0] paddr = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] qat(input logic [31:0] q[$],
                                      input int i);
    return (i < q.size()) ? q[i] : 32'hBAD0_BAD0;
  endfunction

  task automatic model_check();
    bit er = 0;
    if (!reset && p_valid && dec_ready && !redirect_valid) begin
      acc_pc.push_back(p_pc);
      acc_in.push_back(p_instr);
    end
    if (reset) begin
      mq_pc.delete();
      mq_in.delete();
      busy     = 0;
      live     = 0;
      nxt_pc   = RPC;
      exp_addr = RPC;
    end else begin
      er = !busy && !redirect_valid && (mq_pc.size() < DEPTH);
      if (mq_pc.size() != 0 && dec_ready) begin
        void'(mq_pc.pop_front());
        void'(mq_in.pop_front());
      end
      if (busy && ic_ready) begin
        if (live && !redirect_valid) begin
          mq_pc.push_back(out_addr);
          mq_in.push_back(ic_rdata);
          nxt_pc = nxt_pc + 32'd4;
        end
        busy = 0;
      end
      if (redirect_valid) begin
        mq_pc.delete();
        mq_in.delete();
        live   = 0;
        nxt_pc = redirect_pc & 32'hFFFF_FFFC;
      end
      if (er) begin
        busy     = 1;
        live     = 1;
        out_addr = nxt_pc;
        exp_addr = nxt_pc;
      end
    end
    chk("ic_req", 32'(ic_req), 32'(er));
    chk("ic_addr", ic_addr, exp_addr);
    chk("dec_valid", 32'(dec_valid), 32'(mq_pc.size() != 0));
    if (mq_pc.size() != 0) begin
      chk("dec_pc", dec_pc, mq_pc[0]);
      chk("dec_instr", dec_instr, mq_in[0]);
    end
    chk("ic_req_gap", 32'(p_req && ic_req), 32'd0);
    if (ic_req) req_log.push_back(ic_addr);
    p_req   = ic_req;
    p_valid = dec_valid;
    p_pc    = dec_pc;
    p_instr = dec_instr;
  endtask

  task automatic icache_drive();
    ic_ready = 1'b0;
    ic_rdata = $urandom;
    if (reset) begin
      pend = 0;
    end else begin
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          ic_ready = 1'b1;
          ic_rdata = ovr ? 32'hDEAD_BEEF : (paddr ^ 32'hA5A5_A5A5);
          pend     = 0;
        end
      end
      if (ic_req) begin
        pend  = 1;
        cnt   = lat;
        paddr = ic_addr;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_check();
    @(negedge clk);
    icache_drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_reqs(input string nm, input int base,
                           input int want);
    int k = 0;
    while (req_log.size() - base < want && k < 100) begin
      tick();
      k++;
    end
    chk(nm, 32'(req_log.size() - base >= want), 32'd1);
  endtask

  initial begin
    int mark;
    int base;
    int hits;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b0;
    ic_ready       = 1'b0;
    ic_rdata       = '0;

    // sequential stream, icache answers one cycle after each request
    do_reset();
    chk("rst_ic_req", 32'(ic_req), 32'd0);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_ic_addr", ic_addr, RPC);
    lat = 1;
    dec_ready = 1'b1;
    mark = acc_pc.size();
    repeat (20) tick();
    chk("t1_pc0", qat(acc_pc, mark), 32'h0000_0000);
    chk("t1_pc1", qat(acc_pc, mark + 1), 32'h0000_0004);
    chk("t1_pc2", qat(acc_pc, mark + 2), 32'h0000_0008);
    chk("t1_pc3", qat(acc_pc, mark + 3), 32'h0000_000C);
    chk("t1_in0", qat(acc_in, mark), 32'hA5A5_A5A5);
    chk("t1_in3", qat(acc_in, mark + 3), 32'hA5A5_A5A9);

    // back-pressure: FIFO fills, requests stop, one pop frees one slot
    do_reset();
    dec_ready = 1'b0;
    base = req_log.size();
    repeat (20) tick();
    chk("t2_reqs_full", 32'(req_log.size() - base), 32'd2);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    repeat (15) tick();
    chk("t2_reqs_after_pop", 32'(req_log.size() - base), 32'd3);
    chk("t2_third_addr", qat(req_log, base + 2), 32'h0000_0008);

    // redirect while waiting: stale response must be dropped
    do_reset();
    dec_ready = 1'b1;
    lat = 3;
    mark = acc_pc.size();
    wait_reqs("t3_wait_req", req_log.size(), 1);
    ovr = 1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_1003;
    base = req_log.size();
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 10 && !ic_ready; k++) tick();
    chk("t3_stale_ready", 32'(ic_ready), 32'd1);
    tick();
    ovr = 0;
    repeat (20) tick();
    chk("t3_next_addr", qat(req_log, base), 32'h0000_1000);
    chk("t3_first_pc", qat(acc_pc, mark), 32'h0000_1000);
    hits = 0;
    for (int i = mark; i < acc_in.size(); i++) begin
      if (acc_in[i] == 32'hDEAD_BEEF) hits++;
    end
    chk("t3_deadbeef_hits", 32'(hits), 32'd0);

    // redirect in the very cycle the response arrives
    do_reset();
    dec_ready = 1'b0;
    lat = 2;
    wait_reqs("t4_wait_reqs", req_log.size(), 2);
    tick();
    tick();
    chk("t4_ready_now", 32'(ic_ready), 32'd1);
    chk("t4_buffered", 32'(dec_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    chk("t4_flushed", 32'(dec_valid), 32'd0);
    dec_ready = 1'b1;
    base = req_log.size();
    wait_reqs("t4_wait_next", base, 1);
    chk("t4_next_addr", qat(req_log, base), 32'h0000_0200);

    // reset while waiting with one entry buffered
    do_reset();
    dec_ready = 1'b0;
    lat = 3;
    wait_reqs("t5_wait_reqs", req_log.size(), 2);
    chk("t5_buffered", 32'(dec_valid), 32'd1);
    reset = 1'b1;
    tick();
    chk("t5_rst_req", 32'(ic_req), 32'd0);
    chk("t5_rst_valid", 32'(dec_valid), 32'd0);
    reset = 1'b0;
    base = req_log.size();
    wait_reqs("t5_wait_next", base, 1);
    chk("t5_first_addr", qat(req_log, base), RPC);

    // address wrap at the top of the space
    do_reset();
    dec_ready = 1'b1;
    lat = 1;
    wait_reqs("t6_wait_req", req_log.size(), 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    mark = acc_pc.size();
    tick();
    redirect_valid = 1'b0;
    repeat (20) tick();
    chk("t6_pc0", qat(acc_pc, mark), 32'hFFFF_FFFC);
    chk("t6_pc1", qat(acc_pc, mark + 1), 32'h0000_0000);
    chk("t6_in0", qat(acc_in, mark), 32'h5A5A_5A59);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      dec_ready      = ($urandom % 4) != 0;
      lat            = 1 + int'($urandom % 4);
      redirect_valid = ($urandom % 16) == 0;
      redirect_pc    = ($urandom % 4 == 0) ?
                       (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      reset          = ($urandom % 400) == 0;
      tick();
    end
    reset = 1'b0;
    redirect_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
